regfile_dump_reader: RTL and testbench

- Debug reader on the register file's read side: on `start`, walks architectural registers FIRST_REG..LAST_REG through one read port.
- Serialises the values into a framed byte stream with valid/ready handshake, for a UART/debug bridge.
- Replaces probe-based register inspection; shares one register-file read port, muxed in by the top level while the core is halted.

---
 rtl/regfile_dump_reader.sv | 146 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Purpose : walks registers FIRST_REG..LAST_REG through one register-file read port
//           and streams them as a framed byte sequence: header, 4 bytes/reg LE, XOR checksum.
// Latency : first byte valid 1 cycle after start is sampled in IDLE; one CAPTURE bubble per register.
// Backpressure: valid/ready; unbounded stalls, tx_data/tx_valid hold until the handshake.
// Ports   : clk, reset_n (async active-low); start/busy/done control;
//           rf_read_id/rf_read_data register-file read port; tx_data/tx_valid/tx_ready byte stream.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG   = 0,
    parameter int unsigned LAST_REG    = 31,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_id,
    input  logic [31:0] rf_read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [4:0] FIRST_ID = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ID  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CAPTURE,
        S_SEND,
        S_CHECKSUM
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][7:0] word_q, word_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      checksum_q, checksum_d;
    logic [4:0]      rf_read_id_d;
    logic [7:0]      tx_data_d;
    logic            tx_valid_d;
    logic            busy_d;
    logic            done_d;
    logic            hs;

    assign hs = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            byte_idx_q <= 2'd0;
            checksum_q <= 8'h00;
            rf_read_id <= FIRST_ID;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            checksum_q <= checksum_d;
            rf_read_id <= rf_read_id_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Every output is a register, so each branch computes the value the
    // outputs must carry in the cycle after the current edge.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        checksum_d   = checksum_q;
        rf_read_id_d = rf_read_id;
        tx_data_d    = tx_data;
        tx_valid_d   = tx_valid;
        busy_d       = busy;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                checksum_d   = 8'h00;
                rf_read_id_d = FIRST_ID;
                tx_valid_d   = 1'b0;
                busy_d       = 1'b0;
                if (start) begin
                    state_d    = S_HEADER;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER_BYTE;
                    busy_d     = 1'b1;
                end
            end
            S_HEADER: begin
                if (hs) begin
                    state_d    = S_CAPTURE;
                    tx_valid_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                // rf_read_id has been stable for a full cycle, so the
                // combinational read data is settled here.
                word_d     = rf_read_data;
                byte_idx_d = 2'd0;
                tx_data_d  = rf_read_data[7:0];
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    checksum_d = checksum_q ^ tx_data;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = word_q[byte_idx_q + 2'd1];
                    end else if (rf_read_id < LAST_ID) begin
                        rf_read_id_d = rf_read_id + 5'd1;
                        tx_valid_d   = 1'b0;
                        state_d      = S_CAPTURE;
                    end else begin
                        // Fold in the last data byte so the checksum byte is
                        // presented on the very next cycle.
                        tx_data_d = checksum_q ^ tx_data;
                        state_d   = S_CHECKSUM;
                    end
                end
            end
            S_CHECKSUM: begin
                if (hs) begin
                    state_d      = S_IDLE;
                    tx_valid_d   = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    rf_read_id_d = FIRST_ID;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [31:0] regs [32];

    // default-parameter instance
    logic        start0 = 1'b0;
    logic        busy0, done0, tx_valid0;
    logic [4:0]  rf_read_id0;
    logic [31:0] rf_read_data0;
    logic [7:0]  tx_data0;
    logic        tx_ready_w;

    // single-register instance
    logic        start5 = 1'b0;
    logic        busy5, done5, tx_valid5;
    logic [4:0]  rf_read_id5;
    logic [31:0] rf_read_data5;
    logic [7:0]  tx_data5;
    logic        tx_ready5 = 1'b1;

    // register-file model: x0 always reads 0
    assign rf_read_data0 = (rf_read_id0 == 5'd0) ? 32'h0 : regs[rf_read_id0];
    assign rf_read_data5 = (rf_read_id5 == 5'd0) ? 32'h0 : regs[rf_read_id5];

    regfile_dump_reader u_dut (
        .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .done(done0),
        .rf_read_id(rf_read_id0), .rf_read_data(rf_read_data0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready_w)
    );

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .HEADER_BYTE(8'hA5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .busy(busy5), .done(done5),
        .rf_read_id(rf_read_id5), .rf_read_data(rf_read_data5),
        .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready5)
    );

    // ready generation: manual level or random stalls of 1..10 cycles
    logic rand_mode  = 1'b0;
    logic rdy_manual = 1'b1;
    logic rnd_ready  = 1'b1;
    int   stall_left = 0;
    assign tx_ready_w = rand_mode ? rnd_ready : rdy_manual;

    always begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            rnd_ready = 1'b0;
            stall_left--;
        end else begin
            rnd_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 10);
        end
    end

    // stream monitor, sampled on the falling edge
    bq_t        q0, q5;
    int         done_cnt = 0, busy_cnt = 0, stall_viol = 0, id5_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_valid0 && tx_ready_w) q0.push_back(tx_data0);
            if (tx_valid5 && tx_ready5)  q5.push_back(tx_data5);
            if (done0) done_cnt++;
            if (busy0) busy_cnt++;
            if (prev_stall && !(tx_valid0 === 1'b1 && tx_data0 === prev_data)) stall_viol++;
            prev_stall = tx_valid0 && !tx_ready_w;
            prev_data  = tx_data0;
        end else begin
            prev_stall = 1'b0;
        end
        if (rf_read_id5 !== 5'd5) id5_viol++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pclk();
        @(posedge clk);
        #1;
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rf_val(int r);
        return (r == 0) ? 32'h0 : regs[r];
    endfunction

    // expected frame straight from the frame format
    function automatic bq_t build(int first, int last);
        bq_t         q;
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        q.push_back(8'hA5);
        for (int r = first; r <= last; r++) begin
            w = rf_val(r);
            for (int b = 0; b < 4; b++) begin
                q.push_back(w[8*b +: 8]);
                cs ^= w[8*b +: 8];
            end
        end
        q.push_back(cs);
        return q;
    endfunction

    task automatic cmp_q0(input string tag, input int base, input bq_t exp);
        int n;
        n = q0.size() - base;
        check($sformatf("%s_len", tag), n, exp.size());
        for (int i = 0; i < exp.size() && i < n; i++)
            check($sformatf("%s[%0d]", tag, i), {24'h0, q0[base + i]}, {24'h0, exp[i]});
    endtask

    task automatic wait_done0(input string tag);
        int n;
        n = 0;
        do begin
            nclk();
            n++;
        end while (done0 !== 1'b1 && n < 5000);
        check($sformatf("%s_done", tag), done0, 1'b1);
    endtask

    task automatic run0(input string tag, output int base);
        base = q0.size();
        pclk();
        start0 = 1'b1;
        pclk();
        start0 = 1'b0;
        wait_done0(tag);
    endtask

    initial begin
        int   base, d0, b0, n;
        bq_t  e;
        logic [7:0] e5 [6];
        e5 = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;

        // reset state
        #12;
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_valid", tx_valid0, 1'b0);
        check("rst_data", tx_data0, 8'h00);
        check("rst_id", rf_read_id0, 5'd0);
        check("rst_id5", rf_read_id5, 5'd5);
        pclk();
        reset_n = 1'b1;
        pclk();

        // all zero, ready high: latency, busy length, single done
        base = q0.size(); d0 = done_cnt; b0 = busy_cnt;
        pclk();
        start0 = 1'b1;
        check("pre_valid", tx_valid0, 1'b0);
        pclk();
        start0 = 1'b0;
        check("first_valid", tx_valid0, 1'b1);
        check("first_data", tx_data0, 8'hA5);
        check("first_busy", busy0, 1'b1);
        wait_done0("zero");
        check("zero_busy_cycles", busy_cnt - b0, 162);
        check("zero_busy_after", busy0, 1'b0);
        check("zero_id_after", rf_read_id0, 5'd0);
        repeat (5) nclk();
        check("zero_done_once", done_cnt - d0, 1);
        cmp_q0("zero", base, build(0, 31));
        check("zero_cs", q0[base + 129], 8'h00);

        // x1 set, ready high
        regs[1] = 32'h12345678;
        run0("x1", base);
        cmp_q0("x1", base, build(0, 31));
        check("x1_b5", q0[base + 5], 8'h78);
        check("x1_b6", q0[base + 6], 8'h56);
        check("x1_b7", q0[base + 7], 8'h34);
        check("x1_b8", q0[base + 8], 8'h12);
        check("x1_cs", q0[base + 129], 8'h08);

        // same contents under random stalls
        rand_mode = 1'b1;
        run0("x1stall", base);
        cmp_q0("x1stall", base, build(0, 31));

        // random contents (x0 backing value nonzero) under random stalls
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run0("rnd", base);
        cmp_q0("rnd", base, build(0, 31));
        rand_mode = 1'b0;

        // single-register frame
        regs[5] = 32'hDEADBEEF;
        base = q5.size();
        pclk();
        start5 = 1'b1;
        pclk();
        start5 = 1'b0;
        n = 0;
        do begin
            nclk();
            n++;
        end while (done5 !== 1'b1 && n < 200);
        check("one_done", done5, 1'b1);
        check("one_len", q5.size() - base, 6);
        for (int i = 0; i < 6 && base + i < q5.size(); i++)
            check($sformatf("one[%0d]", i), {24'h0, q5[base + i]}, {24'h0, e5[i]});

        // reset while byte 40 is stalled
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        e = build(0, 31);
        rdy_manual = 1'b1;
        base = q0.size(); d0 = done_cnt;
        pclk();
        start0 = 1'b1;
        pclk();
        start0 = 1'b0;
        n = 0;
        while (q0.size() - base < 40 && n < 500) begin
            nclk();
            n++;
        end
        pclk();
        rdy_manual = 1'b0;
        repeat (3) nclk();
        check("stall40_valid", tx_valid0, 1'b1);
        check("stall40_data", tx_data0, e[40]);
        check("stall40_count", q0.size() - base, 40);
        reset_n = 1'b0;
        #1;
        check("abort_valid", tx_valid0, 1'b0);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_data", tx_data0, 8'h00);
        pclk();
        pclk();
        reset_n = 1'b1;
        rdy_manual = 1'b1;
        repeat (3) nclk();
        check("abort_no_done", done_cnt - d0, 0);
        run0("after_rst", base);
        cmp_q0("after_rst", base, e);

        // start held high: back-to-back frames, then a mid-frame pulse
        base = q0.size(); d0 = done_cnt;
        pclk();
        start0 = 1'b1;
        wait_done0("held1");
        check("held1_len", q0.size() - base, 130);
        nclk();
        check("held_restart_valid", tx_valid0, 1'b1);
        check("held_restart_data", tx_data0, 8'hA5);
        start0 = 1'b0;
        repeat (20) pclk();
        start0 = 1'b1;
        pclk();
        start0 = 1'b0;
        wait_done0("held2");
        check("held2_len", q0.size() - base, 260);
        cmp_q0("held2", base + 130, e);
        repeat (20) nclk();
        check("held_no_extra", q0.size() - base, 260);
        check("held_done_cnt", done_cnt - d0, 2);

        check("stall_stable", stall_viol, 0);
        check("id5_fixed", id5_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
